// File: rtl/smvm_job_sequencer.sv
// smvm_job_sequencer: per-job load-order, beat-count and error controller for the CISR SpMV datapath
module smvm_job_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int PIPE_LATENCY   = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] nnz_beats_i,
  input  logic        row_len_rdy_i,
  input  logic        row_len_done_i,
  input  logic        val_ind_rdy_i,
  input  logic        row_len_fifo_overflow_i,
  output logic        dec_clr_o,
  output logic        val_ind_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  error_code_o,
  output logic [15:0] rl_beats_o,
  output logic [31:0] vi_beats_o
);
  // each row-length beat is one NUM_CHANNELS-wide word set; the set count is 16 bits wide
  localparam int RLW = NUM_CHANNELS > 0 ? 16 : 1;
  localparam int DW  = PIPE_LATENCY > 1 ? $clog2(PIPE_LATENCY) : 1;
  localparam int IW  = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD_RL, S_LOAD_VI, S_DRAIN, S_DONE, S_ERROR} state_e;

  state_e         state_q, state_d;
  logic [31:0]    nnz_q, nnz_d;
  logic [RLW-1:0] rl_q, rl_d;
  logic [31:0]    vi_q, vi_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic [2:0]     code_q, code_d;
  logic           dec_clr_q, busy_q, done_q, error_q;
  logic           any_beat, timeout;

  assign any_beat = row_len_rdy_i | row_len_done_i | val_ind_rdy_i;
  assign timeout  = (TIMEOUT_CYCLES != 0) && !any_beat && (32'(idle_q) + 32'd1 == 32'(TIMEOUT_CYCLES));

  assign val_ind_en_o = val_ind_rdy_i & (state_q == S_LOAD_VI);
  assign dec_clr_o    = dec_clr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign error_code_o = code_q;
  assign rl_beats_o   = rl_q;
  assign vi_beats_o   = vi_q;

  // next-state: abort overrides everything, otherwise per-state priority of error checks over beat counting
  always_comb begin
    state_d = state_q;
    nnz_d   = nnz_q;
    rl_d    = rl_q;
    vi_d    = vi_q;
    drain_d = drain_q;
    code_d  = code_q;
    if (abort_i) begin
      state_d = S_IDLE;
      code_d  = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = start_i ? S_CLEAR : S_IDLE;
        S_CLEAR: begin
          nnz_d   = nnz_beats_i;
          rl_d    = '0;
          vi_d    = '0;
          code_d  = 3'd0;
          state_d = S_LOAD_RL;
        end
        S_LOAD_RL: begin
          if (row_len_fifo_overflow_i) begin
            state_d = S_ERROR;
            code_d  = 3'd2;
          end else if (val_ind_rdy_i) begin
            state_d = S_ERROR;
            code_d  = 3'd1;
          end else begin
            if (row_len_rdy_i && rl_q != '1) rl_d = rl_q + 1'b1;
            if (row_len_done_i && !row_len_rdy_i && rl_q == '0) begin
              state_d = S_ERROR;
              code_d  = 3'd5;
            end else if (row_len_done_i) begin
              state_d = (nnz_q == '0) ? S_DRAIN : S_LOAD_VI;
              drain_d = DW'(PIPE_LATENCY - 1);
            end else if (timeout) begin
              state_d = S_ERROR;
              code_d  = 3'd4;
            end
          end
        end
        S_LOAD_VI: begin
          if (row_len_fifo_overflow_i) begin
            state_d = S_ERROR;
            code_d  = 3'd2;
          end else if (row_len_rdy_i) begin
            state_d = S_ERROR;
            code_d  = 3'd1;
          end else if (val_ind_rdy_i) begin
            vi_d = vi_q + 32'd1;
            if (vi_q + 32'd1 == nnz_q) begin
              state_d = S_DRAIN;
              drain_d = DW'(PIPE_LATENCY - 1);
            end
          end else if (timeout) begin
            state_d = S_ERROR;
            code_d  = 3'd4;
          end
        end
        S_DRAIN: begin
          drain_d = drain_q - 1'b1;
          if (val_ind_rdy_i) begin
            state_d = S_ERROR;
            code_d  = 3'd3;
          end else if (drain_q == '0) begin
            state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_ERROR;
      endcase
    end
    idle_d = (state_d == state_q && (state_q == S_LOAD_RL || state_q == S_LOAD_VI) && !any_beat) ? idle_q + 1'b1 : '0;
  end

  // state, counters and registered status outputs derived from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      nnz_q     <= '0;
      rl_q      <= '0;
      vi_q      <= '0;
      drain_q   <= '0;
      idle_q    <= '0;
      code_q    <= '0;
      dec_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      nnz_q     <= nnz_d;
      rl_q      <= rl_d;
      vi_q      <= vi_d;
      drain_q   <= drain_d;
      idle_q    <= idle_d;
      code_q    <= code_d;
      dec_clr_q <= state_d == S_CLEAR;
      busy_q    <= state_d != S_IDLE;
      done_q    <= state_d == S_DONE;
      error_q   <= state_d == S_ERROR;
    end
  end
endmodule
